vga_sync_generator: RTL



---
 rtl/vga_timing_pkg.sv | 41 ++++
 rtl/vga_axis_counter.sv | 50 +++++
 rtl/vga_sync_generator.sv | 118 +++++++++++
 3 files changed

// File: rtl/vga_timing_pkg.sv
// rtl/vga_timing_pkg.sv - 640x480@60 timing defaults, axis phase type and phase lookup
package vga_timing_pkg;

  localparam int H_ACTIVE_DEF = 640;
  localparam int H_FRONT_DEF  = 16;
  localparam int H_SYNC_DEF   = 96;
  localparam int H_BACK_DEF   = 48;
  localparam int H_TOTAL_DEF  = H_ACTIVE_DEF + H_FRONT_DEF + H_SYNC_DEF + H_BACK_DEF;

  localparam int V_ACTIVE_DEF = 480;
  localparam int V_FRONT_DEF  = 10;
  localparam int V_SYNC_DEF   = 2;
  localparam int V_BACK_DEF   = 33;
  localparam int V_TOTAL_DEF  = V_ACTIVE_DEF + V_FRONT_DEF + V_SYNC_DEF + V_BACK_DEF;

  typedef enum logic [1:0] {
    PH_ACTIVE,
    PH_FRONT,
    PH_SYNC,
    PH_BACK
  } phase_t;

  // Phase boundaries are the running sums of the four segment lengths.
  // A count past the end of the line/frame belongs to the next one, which
  // starts with the active segment.
  function automatic phase_t phase_of(input int count, input int active,
                                      input int front, input int sync,
                                      input int back);
    if (count < active)
      return PH_ACTIVE;
    else if (count < active + front)
      return PH_FRONT;
    else if (count < active + front + sync)
      return PH_SYNC;
    else if (count < active + front + sync + back)
      return PH_BACK;
    else
      return PH_ACTIVE;
  endfunction

endpackage

// File: rtl/vga_axis_counter.sv
// rtl/vga_axis_counter.sv - one raster axis: wrapping position counter with phase tracking
module vga_axis_counter
  import vga_timing_pkg::*;
#(
  parameter int CNT_W  = 10,
  parameter int ACTIVE = H_ACTIVE_DEF,
  parameter int FRONT  = H_FRONT_DEF,
  parameter int SYNC   = H_SYNC_DEF,
  parameter int BACK   = H_BACK_DEF
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             advance,
  output logic [CNT_W-1:0] count_next,
  output phase_t           phase_next,
  output logic             at_end,
  output logic             wrap
);

  localparam int               TOTAL = ACTIVE + FRONT + SYNC + BACK;
  localparam logic [CNT_W-1:0] LAST  = CNT_W'(TOTAL - 1);

  logic [CNT_W-1:0] count;
  phase_t           phase;

  // Next position and phase; both hold when the axis is not advancing.
  always_comb begin
    at_end     = (count == LAST);
    count_next = count;
    phase_next = phase;
    if (advance) begin
      count_next = at_end ? '0 : count + 1'b1;
      phase_next = phase_of(int'(count_next), ACTIVE, FRONT, SYNC, BACK);
    end
  end

  // Reset parks the axis on its last position so the first advance lands on 0.
  always_ff @(posedge clock) begin
    if (reset) begin
      count <= LAST;
      phase <= phase_of(TOTAL - 1, ACTIVE, FRONT, SYNC, BACK);
      wrap  <= 1'b0;
    end else begin
      count <= count_next;
      phase <= phase_next;
      wrap  <= advance && at_end;
    end
  end

endmodule

// File: rtl/vga_sync_generator.sv
// rtl/vga_sync_generator.sv - VGA raster timing top; VGA_FRAME_COUNT_EN adds an 8-bit frameCount output
module vga_sync_generator
  import vga_timing_pkg::*;
#(
  parameter int H_ACTIVE         = H_ACTIVE_DEF,
  parameter int H_FRONT          = H_FRONT_DEF,
  parameter int H_SYNC           = H_SYNC_DEF,
  parameter int H_BACK           = H_BACK_DEF,
  parameter int V_ACTIVE         = V_ACTIVE_DEF,
  parameter int V_FRONT          = V_FRONT_DEF,
  parameter int V_SYNC           = V_SYNC_DEF,
  parameter int V_BACK           = V_BACK_DEF,
  parameter int SYNC_ACTIVE_HIGH = 0,
  parameter int CNT_W            = 10
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             pixelTick,
  output logic             hSync,
  output logic             vSync,
  output logic             displayActive,
  output logic [CNT_W-1:0] pixelX,
  output logic [CNT_W-1:0] pixelY,
  output logic             lineTick,
  output logic             frameTick
`ifdef VGA_FRAME_COUNT_EN
  ,
  output logic [7:0]       frameCount
`endif
);

  localparam logic             SYNC_ON    = (SYNC_ACTIVE_HIGH != 0);
  localparam logic [CNT_W-1:0] FRAME_LINE = CNT_W'(V_ACTIVE);

  logic [CNT_W-1:0] h_count_next;
  logic [CNT_W-1:0] v_count_next;
  phase_t           h_phase_next;
  phase_t           v_phase_next;
  logic             h_at_end;
  logic             h_wrap;
  logic             v_at_end;
  logic             v_wrap;
  logic             v_advance;
  logic             active_next;
  logic             frame_edge;

  // The vertical axis only needs its position; its own end/wrap flags go unused.
  logic unused_v;
  assign unused_v = &{1'b0, v_at_end, v_wrap};

  vga_axis_counter #(
    .CNT_W  (CNT_W),
    .ACTIVE (H_ACTIVE),
    .FRONT  (H_FRONT),
    .SYNC   (H_SYNC),
    .BACK   (H_BACK)
  ) h_axis (
    .clock      (clock),
    .reset      (reset),
    .advance    (pixelTick),
    .count_next (h_count_next),
    .phase_next (h_phase_next),
    .at_end     (h_at_end),
    .wrap       (h_wrap)
  );

  vga_axis_counter #(
    .CNT_W  (CNT_W),
    .ACTIVE (V_ACTIVE),
    .FRONT  (V_FRONT),
    .SYNC   (V_SYNC),
    .BACK   (V_BACK)
  ) v_axis (
    .clock      (clock),
    .reset      (reset),
    .advance    (v_advance),
    .count_next (v_count_next),
    .phase_next (v_phase_next),
    .at_end     (v_at_end),
    .wrap       (v_wrap)
  );

  assign v_advance   = pixelTick && h_at_end;
  assign active_next = (h_phase_next == PH_ACTIVE) && (v_phase_next == PH_ACTIVE);
  // Entering (0, V_ACTIVE): the first blanking line, so frame updates land off-screen.
  assign frame_edge  = v_advance && (v_count_next == FRAME_LINE);
  assign lineTick    = h_wrap;

  // Outputs are registered from the next position so they line up with the counters.
  always_ff @(posedge clock) begin
    if (reset) begin
      hSync         <= !SYNC_ON;
      vSync         <= !SYNC_ON;
      displayActive <= 1'b0;
      pixelX        <= '0;
      pixelY        <= '0;
      frameTick     <= 1'b0;
    end else begin
      hSync         <= (h_phase_next == PH_SYNC) ? SYNC_ON : !SYNC_ON;
      vSync         <= (v_phase_next == PH_SYNC) ? SYNC_ON : !SYNC_ON;
      displayActive <= active_next;
      pixelX        <= active_next ? h_count_next : '0;
      pixelY        <= active_next ? v_count_next : '0;
      frameTick     <= frame_edge;
    end
  end

`ifdef VGA_FRAME_COUNT_EN
  // Frame counter steps on the same edge that raises frameTick, wrapping naturally at 8 bits.
  always_ff @(posedge clock) begin
    if (reset)
      frameCount <= 8'd0;
    else if (frame_edge)
      frameCount <= frameCount + 8'd1;
  end
`endif

endmodule
